// File: rtl/hub_slot_ctrl_if.sv
// rtl/hub_slot_ctrl_if.sv - cog/hub handshake bundle for the hub slot sequencer
//
// Signals
//   req      8  per-cog hub request level, held until acknowledge
//   bus_ack  8  per-cog acknowledge pulse returned by the hub
//   ena_bus  1  one-cycle hub enable pulse
//   bus_sel  8  one-hot slot owner
//   grant    8  issue pulse, coincident with ena_bus
//   busy     8  per-cog request in flight (state != IDLE)
// Modports
//   slave   the sequencer: consumes req/bus_ack, drives the rest
//   master  the cog/hub side
interface hub_slot_ctrl_if;
    logic [7:0] req;
    logic [7:0] bus_ack;
    logic       ena_bus;
    logic [7:0] bus_sel;
    logic [7:0] grant;
    logic [7:0] busy;

    modport slave (
        input  req,
        input  bus_ack,
        output ena_bus,
        output bus_sel,
        output grant,
        output busy
    );

    modport master (
        output req,
        output bus_ack,
        input  ena_bus,
        input  bus_sel,
        input  grant,
        input  busy
    );
endinterface

// File: rtl/hub_slot_ctrl.sv
// rtl/hub_slot_ctrl.sv - hub time-slot sequencer and per-cog access tracker
//
// Derives the hub enable pulse from clk_cog, rotates the one-hot slot owner,
// and tracks each cog's request IDLE -> WAIT -> ISSUED -> IDLE, flagging
// acknowledge timeouts and spurious acknowledges.
//
// Parameters
//   ENA_DIV  clk_cog cycles per ena_bus pulse (2..15)
//   ACK_TMO  ena_bus ticks allowed in ISSUED before timeout (3..15)
// Ports
//   clk_cog   in   cog clock
//   nres      in   asynchronous active-low reset
//   hub       if   req/bus_ack in, ena_bus/bus_sel/grant/busy out
//   err_tmo   out  sticky per-cog acknowledge timeout
//   err_spur  out  sticky per-cog acknowledge with nothing outstanding
//   err_clr   in   clears err_tmo and err_spur (a same-cycle set wins)
//   stat_sel  in   cog index for the stats read
//   stat_q    out  max WAIT ticks for cog stat_sel, one clock after stat_sel
//   stat_clr  in   clears all max registers (a same-cycle update wins)
// Optional feature
//   HUB_SLOT_STATS_EN  builds the WAIT-tick statistics; otherwise stat_q is 0
module hub_slot_ctrl #(
    parameter int ENA_DIV = 2,
    parameter int ACK_TMO = 4
) (
    input  logic                  clk_cog,
    input  logic                  nres,
    hub_slot_ctrl_if.slave        hub,
    output logic [7:0]            err_tmo,
    output logic [7:0]            err_spur,
    input  logic                  err_clr,
    input  logic [2:0]            stat_sel,
    output logic [15:0]           stat_q,
    input  logic                  stat_clr
);
    localparam logic [3:0] DIV_LAST = 4'(ENA_DIV - 1);
    localparam logic [3:0] TMO_LAST = 4'(ACK_TMO - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ISSUED = 2'd2
    } cog_state_t;

    logic [3:0] div_cnt;
    logic       ena_q;
    logic [7:0] sel_q;

    cog_state_t state     [8];
    cog_state_t state_nxt [8];
    logic [3:0] tmo_cnt   [8];

    logic [7:0] grant_c;
    logic [7:0] tmo_hit;
    logic [7:0] spur_hit;
    logic [7:0] busy_c;

    assign hub.ena_bus = ena_q;
    assign hub.bus_sel = sel_q;
    assign hub.grant   = grant_c;
    assign hub.busy    = busy_c;

    // ena_bus is registered off the terminal count, so the first pulse
    // lands ENA_DIV clocks after reset release.
    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            div_cnt <= 4'd0;
            ena_q   <= 1'b0;
            sel_q   <= 8'h01;
        end else begin
            ena_q   <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
            if (ena_q) begin
                sel_q <= {sel_q[6:0], sel_q[7]};
            end
        end
    end

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            for (int n = 0; n < 8; n++) begin
                state[n] <= S_IDLE;
            end
        end else begin
            for (int n = 0; n < 8; n++) begin
                state[n] <= state_nxt[n];
            end
        end
    end

    always_comb begin
        grant_c  = 8'h00;
        tmo_hit  = 8'h00;
        spur_hit = 8'h00;
        busy_c   = 8'h00;
        for (int n = 0; n < 8; n++) begin
            state_nxt[n] = state[n];
            busy_c[n]    = (state[n] != S_IDLE);
            spur_hit[n]  = hub.bus_ack[n] && (state[n] != S_ISSUED);
            case (state[n])
                // A request arriving on its own slot skips WAIT entirely.
                S_IDLE: begin
                    if (ena_q && sel_q[n] && hub.req[n]) begin
                        state_nxt[n] = S_ISSUED;
                        grant_c[n]   = 1'b1;
                    end else if (hub.req[n]) begin
                        state_nxt[n] = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ena_q && sel_q[n] && hub.req[n]) begin
                        state_nxt[n] = S_ISSUED;
                        grant_c[n]   = 1'b1;
                    end else if (!hub.req[n]) begin
                        state_nxt[n] = S_IDLE;
                    end
                end
                // Ack is tested first so it beats a coincident timeout.
                S_ISSUED: begin
                    if (hub.bus_ack[n]) begin
                        state_nxt[n] = S_IDLE;
                    end else if (ena_q && (tmo_cnt[n] >= TMO_LAST)) begin
                        state_nxt[n] = S_IDLE;
                        tmo_hit[n]   = 1'b1;
                    end
                end
                default: begin
                    state_nxt[n] = S_IDLE;
                end
            endcase
        end
    end

    // Counts ena_bus ticks since issue; saturating so it can never wrap
    // back under the timeout threshold.
    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            for (int n = 0; n < 8; n++) begin
                tmo_cnt[n] <= 4'd0;
            end
        end else begin
            for (int n = 0; n < 8; n++) begin
                if (grant_c[n]) begin
                    tmo_cnt[n] <= 4'd0;
                end else if ((state[n] == S_ISSUED) && ena_q && (tmo_cnt[n] != 4'hF)) begin
                    tmo_cnt[n] <= tmo_cnt[n] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            err_tmo  <= 8'h00;
            err_spur <= 8'h00;
        end else begin
            err_tmo  <= (err_tmo  & ~{8{err_clr}}) | tmo_hit;
            err_spur <= (err_spur & ~{8{err_clr}}) | spur_hit;
        end
    end

`ifdef HUB_SLOT_STATS_EN
    logic [3:0]  wait_cnt [8];
    logic [15:0] max_q    [8];

    // wait_cnt counts ena_bus ticks spent in WAIT, excluding the granting
    // tick itself; the max is sampled on the WAIT->ISSUED transition.
    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            for (int n = 0; n < 8; n++) begin
                wait_cnt[n] <= 4'd0;
                max_q[n]    <= 16'h0000;
            end
            stat_q <= 16'h0000;
        end else begin
            for (int n = 0; n < 8; n++) begin
                if ((state[n] != S_WAIT) && (state_nxt[n] == S_WAIT)) begin
                    wait_cnt[n] <= 4'd0;
                end else if ((state[n] == S_WAIT) && (state_nxt[n] == S_WAIT) &&
                             ena_q && (wait_cnt[n] != 4'hF)) begin
                    wait_cnt[n] <= wait_cnt[n] + 4'd1;
                end
                if ((state[n] == S_WAIT) && grant_c[n] &&
                    ({12'h000, wait_cnt[n]} > max_q[n])) begin
                    max_q[n] <= {12'h000, wait_cnt[n]};
                end else if (stat_clr) begin
                    max_q[n] <= 16'h0000;
                end
            end
            stat_q <= max_q[stat_sel];
        end
    end
`else
    logic stats_unused;
    assign stats_unused = ^{stat_sel, stat_clr};
    assign stat_q       = 16'h0000;
`endif

endmodule

// File: tb/tb_hub_slot_ctrl.sv
// tb/tb_hub_slot_ctrl.sv - self-checking bench for hub_slot_ctrl
module tb_hub_slot_ctrl;
    logic        clk_cog = 1'b0;
    logic        nres;
    logic [7:0]  err_tmo;
    logic [7:0]  err_spur;
    logic        err_clr;
    logic [2:0]  stat_sel;
    logic [15:0] stat_q;
    logic        stat_clr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cyc0     = 0;

    always #5 clk_cog = ~clk_cog;

    hub_slot_ctrl_if hub ();

    hub_slot_ctrl #(.ENA_DIV(2), .ACK_TMO(4)) dut (
        .clk_cog  (clk_cog),
        .nres     (nres),
        .hub      (hub),
        .err_tmo  (err_tmo),
        .err_spur (err_spur),
        .err_clr  (err_clr),
        .stat_sel (stat_sel),
        .stat_q   (stat_q),
        .stat_clr (stat_clr)
    );

    typedef struct {
        logic       ena;
        logic [7:0] sel;
    } rot_vec_t;

    rot_vec_t rot_tab [18];

    task automatic tick();
        @(posedge clk_cog);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ena();
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!hub.ena_bus && k < 40);
        check("wait_ena", 32'(hub.ena_bus), 32'd1);
    endtask

    task automatic wait_grant(input int n);
        int k;
        k = 0;
        while (!hub.grant[n] && k < 40) begin
            tick();
            k++;
        end
        check($sformatf("grant%0d_seen", n), 32'(hub.grant[n]), 32'd1);
    endtask

    task automatic wait_slot(input logic [7:0] s);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!(hub.ena_bus && hub.bus_sel == s) && k < 40);
        check("wait_slot", 32'({hub.ena_bus, hub.bus_sel}), 32'({1'b1, s}));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rot_tab[0]  = '{1'b0, 8'h01}; rot_tab[1]  = '{1'b1, 8'h01};
        rot_tab[2]  = '{1'b0, 8'h02}; rot_tab[3]  = '{1'b1, 8'h02};
        rot_tab[4]  = '{1'b0, 8'h04}; rot_tab[5]  = '{1'b1, 8'h04};
        rot_tab[6]  = '{1'b0, 8'h08}; rot_tab[7]  = '{1'b1, 8'h08};
        rot_tab[8]  = '{1'b0, 8'h10}; rot_tab[9]  = '{1'b1, 8'h10};
        rot_tab[10] = '{1'b0, 8'h20}; rot_tab[11] = '{1'b1, 8'h20};
        rot_tab[12] = '{1'b0, 8'h40}; rot_tab[13] = '{1'b1, 8'h40};
        rot_tab[14] = '{1'b0, 8'h80}; rot_tab[15] = '{1'b1, 8'h80};
        rot_tab[16] = '{1'b0, 8'h01}; rot_tab[17] = '{1'b1, 8'h01};

        nres        = 1'b0;
        hub.req     = 8'h00;
        hub.bus_ack = 8'h00;
        err_clr     = 1'b0;
        stat_sel    = 3'd0;
        stat_clr    = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_ena_bus", 32'(hub.ena_bus), 32'd0);
        check("rst_bus_sel", 32'(hub.bus_sel), 32'h01);
        check("rst_busy",    32'(hub.busy),    32'h00);
        check("rst_grant",   32'(hub.grant),   32'h00);
        check("rst_err",     32'({err_tmo, err_spur}), 32'h0);
        check("rst_stat_q",  32'(stat_q),      32'h0);

        // Divider and rotation, clocks 1..18 after release
        @(posedge clk_cog);
        #1;
        nres = 1'b1;
        cyc  = 0;
        for (int i = 0; i < 18; i++) begin
            tick();
            check($sformatf("rot_clk%0d", cyc), 32'({hub.ena_bus, hub.bus_sel}),
                  32'({rot_tab[i].ena, rot_tab[i].sel}));
        end

        // req[3] raised in the sel=01 pulse: granted at sel=08, acked 2 ticks later
        cyc0    = cyc;
        hub.req = 8'h08;
        wait_grant(3);
        check("a_grant_latency", 32'(cyc - cyc0), 32'd6);
        check("a_grant_sel",     32'(hub.bus_sel), 32'h08);
        check("a_grant_onehot",  32'(hub.grant),   32'h08);
        tick();
        hub.req = 8'h00;
        check("a_busy_issued", 32'(hub.busy[3]), 32'd1);
        wait_ena();
        wait_ena();
        hub.bus_ack = 8'h08;
        tick();
        hub.bus_ack = 8'h00;
        check("a_busy_done", 32'(hub.busy[3]), 32'd0);
        check("a_no_err",    32'({err_tmo, err_spur}), 32'h0);

        // req[5] with ack withheld: timeout on the 4th tick after issue
        hub.req = 8'h20;
        wait_grant(5);
        tick();
        hub.req = 8'h00;
        wait_ena();
        wait_ena();
        wait_ena();
        check("b_busy_t3", 32'(hub.busy[5]), 32'd1);
        wait_ena();
        check("b_tmo_pre", 32'(err_tmo), 32'h00);
        tick();
        check("b_tmo_set",  32'(err_tmo), 32'h20);
        check("b_busy_tmo", 32'(hub.busy[5]), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("b_tmo_clr", 32'(err_tmo), 32'h00);

        // ack on the same tick as the timeout: ack wins
        hub.req = 8'h40;
        wait_grant(6);
        tick();
        hub.req = 8'h00;
        wait_ena();
        wait_ena();
        wait_ena();
        wait_ena();
        hub.bus_ack = 8'h40;
        tick();
        hub.bus_ack = 8'h00;
        check("b2_ack_wins", 32'({err_tmo, err_spur}), 32'h0);
        check("b2_busy",     32'(hub.busy[6]), 32'd0);

        // spurious ack on idle cog2; then clear colliding with a new set
        hub.bus_ack = 8'h04;
        tick();
        hub.bus_ack = 8'h00;
        check("c_spur_set", 32'(err_spur), 32'h04);
        check("c_busy",     32'(hub.busy), 32'h00);
        err_clr     = 1'b1;
        hub.bus_ack = 8'h02;
        tick();
        err_clr     = 1'b0;
        hub.bus_ack = 8'h00;
        check("c_set_wins", 32'(err_spur), 32'h02);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("c_spur_clr", 32'(err_spur), 32'h00);

        // req[0] and req[7] raised together in the sel=02 pulse
        wait_slot(8'h02);
        hub.req = 8'h81;
        wait_grant(7);
        check("d_sel7",     32'(hub.bus_sel), 32'h80);
        check("d_grant7_1", 32'(hub.grant),   32'h80);
        cyc0 = cyc;
        tick();
        hub.req = 8'h01;
        wait_grant(0);
        check("d_grant0_next", 32'(cyc - cyc0), 32'd2);
        check("d_sel0",        32'(hub.bus_sel), 32'h01);
        tick();
        hub.req = 8'h00;
        wait_ena();
        wait_ena();
        wait_ena();
        wait_ena();
        tick();
        check("d_tmo_both", 32'(err_tmo),  32'h81);
        check("d_busy_end", 32'(hub.busy), 32'h00);
`ifdef HUB_SLOT_STATS_EN
        stat_sel = 3'd3;
        tick();
        check("stat_cog3", 32'(stat_q), 32'd2);
        stat_sel = 3'd7;
        tick();
        check("stat_cog7", 32'(stat_q), 32'd5);
        stat_sel = 3'd0;
        tick();
        check("stat_cog0", 32'(stat_q), 32'd6);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        tick();
        check("stat_clr", 32'(stat_q), 32'd0);
`else
        stat_sel = 3'd7;
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("stat_tied", 32'(stat_q), 32'd0);
`endif

        // reset while cog4 is ISSUED, with err_tmo still set from above
        hub.req = 8'h10;
        wait_grant(4);
        tick();
        hub.req = 8'h00;
        check("e_busy_issued", 32'(hub.busy[4]), 32'd1);
        nres = 1'b0;
        #2;
        check("e_rst_busy",   32'(hub.busy),    32'h00);
        check("e_rst_sel",    32'(hub.bus_sel), 32'h01);
        check("e_rst_err",    32'({err_tmo, err_spur}), 32'h0);
        check("e_rst_stat_q", 32'(stat_q),      32'h0);
        hub.req = 8'h01;
        #2;
        nres = 1'b1;
        tick();
        check("e_no_early_grant", 32'({hub.ena_bus, hub.grant}), 32'h000);
        tick();
        check("e_first_grant", 32'({hub.ena_bus, hub.grant}), 32'h101);
        tick();
        hub.req     = 8'h00;
        hub.bus_ack = 8'h10;
        tick();
        hub.bus_ack = 8'h00;
        check("e_late_ack_spur", 32'(err_spur), 32'h10);
        check("e_busy4",         32'(hub.busy[4]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
